// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network datapath: default widths,
// saturation bounds and the accumulator state encoding.
package snn_pkg;

  localparam int V_SIZE_DEF = 4;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  function automatic int sat_max(input int v);
    return (1 << (v - 1)) - 1;
  endfunction

  function automatic int sat_min(input int v);
    return -(1 << (v - 1));
  endfunction

endpackage

// File: rtl/sat_adder.sv
// Combinational signed saturating adder. Overflow is possible only when both
// operands share a sign and the wrapped result flips it.
module sat_adder
  import snn_pkg::*;
#(
  parameter int V_SIZE = V_SIZE_DEF
) (
  input  logic signed [V_SIZE-1:0] a,
  input  logic signed [V_SIZE-1:0] b,
  output logic signed [V_SIZE-1:0] y
);

  localparam logic signed [V_SIZE-1:0] SMAX = V_SIZE'(sat_max(V_SIZE));
  localparam logic signed [V_SIZE-1:0] SMIN = V_SIZE'(sat_min(V_SIZE));

  logic signed [V_SIZE-1:0] raw;
  logic                     ovf;

  always_comb begin
    raw = a + b;
    ovf = (a[V_SIZE-1] == b[V_SIZE-1]) && (raw[V_SIZE-1] != a[V_SIZE-1]);
    y   = raw;
    if (ovf) y = a[V_SIZE-1] ? SMIN : SMAX;
  end

endmodule

// File: rtl/synapse_accumulator.sv
// Serial presynaptic integrator: latches a spike vector, walks it one synapse
// per cycle adding gated weights with saturation, then offers the sum.
module synapse_accumulator
  import snn_pkg::*;
#(
  parameter int N_IN   = 8,
  parameter int V_SIZE = V_SIZE_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_IN*V_SIZE-1:0]   weights,
  input  logic [N_IN-1:0]          spike_vec,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [V_SIZE-1:0] sum_out,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int IDX_W = $clog2(N_IN);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_IN - 1);

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic signed [V_SIZE-1:0] acc_q, acc_d;
  logic signed [V_SIZE-1:0] sum_q, sum_d;
  logic [N_IN-1:0]          spk_q, spk_d;

  logic signed [V_SIZE-1:0] w_arr [N_IN];
  logic signed [V_SIZE-1:0] acc_sum;
  logic signed [V_SIZE-1:0] acc_next;

  for (genvar g = 0; g < N_IN; g++) begin : g_w
    assign w_arr[g] = weights[g*V_SIZE +: V_SIZE];
  end

  sat_adder #(.V_SIZE(V_SIZE)) u_add (
    .a (acc_q),
    .b (w_arr[idx_q]),
    .y (acc_sum)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    sum_d    = sum_q;
    spk_d    = spk_q;
    acc_next = spk_q[idx_q] ? acc_sum : acc_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          spk_d   = spike_vec;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_next;
        idx_d = idx_q + 1'b1;
        // Publish on the last synapse so sum_out holds the result through IDLE.
        if (idx_q == LAST) begin
          idx_d   = '0;
          sum_d   = acc_next;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      spk_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      spk_q   <= spk_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign sum_out   = sum_q;

endmodule

// File: doc/synapse_accumulator.md
# synapse_accumulator

Serial presynaptic integrator that produces the signed per-timestep input drive consumed by an LIF neuron's `spike_in` port. It accepts a vector of binary presynaptic spikes through a valid/ready handshake and walks the vector one synapse per cycle, adding each active synapse's signed weight with saturation. It presents the clipped `V_SIZE`-bit sum through a second valid/ready handshake. It sits between the spike fabric (neuron `spike_out` bits) and each neuron's input.

## Interface
- `N_IN`, default 8: number of presynaptic inputs; must be ≥ 2.
- `V_SIZE`, default 4: width of weights and of the result, two's complement.
- `clk` input, 1 bit: the single clock; all state changes on its rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `weights` input, `N_IN*V_SIZE` bits: static signed weights. Weight i is `weights[i*V_SIZE +: V_SIZE]`. Must not change during a transaction.
- `spike_vec` input, `N_IN` bits: presynaptic spikes; bit i gates weight i.
- `in_valid` input, 1 bit: the `spike_vec` offer is valid.
- `in_ready` output, 1 bit: the block can accept a new `spike_vec`.
- `sum_out` output, `V_SIZE` bits, signed: saturated weighted sum.
- `out_valid` output, 1 bit: `sum_out` holds a fresh result.
- `out_ready` input, 1 bit: the consumer accepts `sum_out`.

## Operation
- **States:** IDLE, ACCUM, DONE.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid & in_ready`: latch `spike_vec` into an internal register, clear the accumulator and index, go to ACCUM.
  - `in_valid`=0 keeps the block in IDLE.
- **ACCUM:**
  - `in_ready`=0.
  - Each cycle: if latched bit[idx]=1, acc ← sat_add(acc, w[idx]); otherwise acc is unchanged.
  - idx increments; on the cycle idx = `N_IN`-1, go to DONE.
  - Order is fixed, index 0 first.
  - Saturation applies at every step, so intermediate clipping is order-dependent. This behaviour is required.
- **Saturation:**
  - Results above 2^(`V_SIZE`-1)-1 clip to SAT_MAX.
  - Results below -2^(`V_SIZE`-1) clip to SAT_MIN.
  - No wrap-around is ever visible.
- **DONE:**
  - `out_valid`=1 and `sum_out`=acc; both stay stable until `out_ready`=1.
  - On `out_valid & out_ready`: go to IDLE.
  - `in_valid` is ignored while in DONE.
- **`sum_out` outside DONE:** holds the last completed result; it is 0 after reset.
- **Reset:**
  - Asserting `rst` in any state immediately forces IDLE, acc=0, idx=0, latched vector=0, `sum_out`=0 and `out_valid`=0.
  - `in_ready`=0 while `rst` is high.
  - A transaction interrupted by reset is discarded; no partial result is emitted.
- **Edge cases:**
  - An all-zero `spike_vec` still takes the full `N_IN` cycles and yields 0.
  - The `spike_vec` input may change freely after its acceptance cycle.

## Timing
- Input handshake completes on edge T.
- ACCUM occupies edges T+1 … T+`N_IN`.
- `out_valid` rises after edge T+`N_IN`, so latency is `N_IN`+1 cycles from acceptance to result.
- Output handshake completes on edge D; `out_valid` falls and `in_ready` rises after edge D.
- Maximum throughput is one transaction per `N_IN`+2 cycles with `in_valid` and `out_ready` held high.
- All outputs are registered, or decoded only from the state register, gated by `rst` for `in_ready`. There is no combinational path from inputs to outputs.

## Structure
- **Shared package `snn_pkg`:**
  - `V_SIZE` default.
  - SAT_MAX / SAT_MIN derivation, as functions of `V_SIZE`.
  - State enum: IDLE / ACCUM / DONE.
- **Sub-module `sat_adder`:**
  - Combinational two-operand signed saturating add, parameterised on `V_SIZE`.
  - Overflow is detected from the operand sign bits versus the result sign bit.
- **Index counter width:** `$clog2(N_IN)`.

## Test plan
All scenarios use bench parameters `N_IN`=4, `V_SIZE`=4 (range -8…7).
- **Reset:** hold `rst` high mid-idle → `in_ready`=0, `out_valid`=0, `sum_out`=0. Release `rst` → `in_ready`=1 on the next cycle.
- **Basic sum:** weights {w0=3, w1=-2, w2=1, w3=2}, `spike_vec`=4'b1011 → `sum_out`=3 with `out_valid` exactly 5 cycles after acceptance. `spike_vec`=0 → `sum_out`=0 with the same latency.
- **Saturation:**
  - All weights 7, `spike_vec`=4'b1111 → 7.
  - All weights -8 → -8.
  - Order-dependent case: weights {7, 7, -8, 0}, `spike_vec`=4'b0111 → intermediate 7, 7 (clipped), -1; final `sum_out`=-1.
- **Backpressure:** hold `out_ready`=0 for 6 cycles in DONE, with `in_valid`=1 and `spike_vec` toggling.
  - `out_valid` and `sum_out` stay stable, `in_ready` stays 0.
  - Raising `out_ready` completes the handshake; `in_ready`=1 on the next cycle.
- **Reset mid-operation:** assert `rst` on the second ACCUM cycle → `out_valid` never rises and `sum_out`=0. A following transaction (weights {3,-2,1,2}, `spike_vec`=4'b1011) gives 3.
- **Back-to-back:** `in_valid` and `out_ready` held high across 3 transactions → results arrive every 6 cycles in order, and none is dropped or duplicated.
